// File: rtl/demux_stream.sv
// demux_stream: routes a valid/ready input stream to one of N output channels
// (or to all of them on broadcast). Each channel owns a small FIFO so that a
// stalled consumer only blocks beats addressed to its own channel.
// Beats addressed to a channel index >= N are accepted and counted as drops.
module demux_stream #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int DEPTH = 2,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [7:0]           drop_cnt
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
    localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);

    logic         in_range;
    logic         sel_not_full;
    logic         accept;
    logic         drop_inc;
    logic [N-1:0] not_full;
    logic [N-1:0] push;

    // A select can only be out of range when N is not a power of two.
    assign in_range = ({1'b0, in_sel} < N_EXT);

    // Ready is built from registered occupancy only, so out_ready never
    // reaches in_ready combinationally; a pop frees space one cycle later.
    always_comb begin
        sel_not_full = 1'b0;
        push         = '0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SELW'(k)) begin
                sel_not_full = not_full[k];
            end
        end
        if (in_bcast) begin
            in_ready = &not_full;
        end else if (in_range) begin
            in_ready = sel_not_full;
        end else begin
            in_ready = 1'b1;
        end
        accept   = in_valid & in_ready;
        drop_inc = accept & ~in_bcast & ~in_range;
        for (int k = 0; k < N; k++) begin
            push[k] = accept & (in_bcast | (in_range & (in_sel == SELW'(k))));
        end
    end

    // Saturating count of beats discarded for an out-of-range select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop_inc && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTRW-1:0]  wr_ptr;
        logic [PTRW-1:0]  rd_ptr;
        logic [CNTW-1:0]  occ;
        logic             pop;

        assign not_full[g]  = (occ < DEPTH_C);
        assign out_valid[g] = (occ != '0);
        assign pop          = out_valid[g] & out_ready[g];
        assign out_data[g*WIDTH +: WIDTH] = mem[rd_ptr];

        // Occupancy and wrapping pointers; push and pop together keep occupancy.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTRW'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTRW'(1);
                end
                if (push[g] && !pop) begin
                    occ <= occ + CNTW'(1);
                end else if (!push[g] && pop) begin
                    occ <= occ - CNTW'(1);
                end
            end
        end

        // Payload storage is not reset; out_valid qualifies the head entry.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8, data bits per beat.
REQ-002 Parameter N, default 4, number of output channels; legal 2..16.
REQ-003 Parameter DEPTH, default 2, per-channel buffer entries; legal 2..8.
REQ-004 Derived SELW = clog2(N), minimum 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  input beat accepted this cycle when high with in_valid.
REQ-009 in_data  input  WIDTH  input payload.
REQ-010 in_sel  input  SELW  destination channel index.
REQ-011 in_bcast  input  1  deliver beat to all N channels; in_sel ignored.
REQ-012 out_valid  output  N  per-channel beat present.
REQ-013 out_ready  input  N  per-channel consumer ready.
REQ-014 out_data  output  N*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
REQ-015 drop_cnt  output  8  count of beats dropped for out-of-range in_sel.

Function
REQ-016 Each channel SHALL contain a DEPTH-entry FIFO with occupancy counter 0..DEPTH, read/write pointers wrapping DEPTH-1 -> 0.
REQ-017 Accept = in_valid & in_ready; the module SHALL push in_data into the target FIFO(s) on accept.
REQ-018 Unicast (in_bcast=0, in_sel<N): in_ready SHALL equal (occupancy of channel in_sel) < DEPTH.
REQ-019 Broadcast (in_bcast=1): in_ready SHALL be high only when every channel has occupancy < DEPTH; on accept the beat SHALL be pushed into all N FIFOs in the same cycle.
REQ-020 Out-of-range (in_bcast=0, in_sel>=N): in_ready SHALL be 1, no FIFO written, drop_cnt incremented on accept, saturating at 255.
REQ-021 in_ready SHALL depend only on registered occupancy, in_sel and in_bcast; no combinational path from out_ready.
REQ-022 Push to a full FIFO SHALL never occur, even if the same channel pops that cycle (full-cycle pop frees space visible next cycle).
REQ-023 out_valid[k] SHALL be (occupancy k != 0); out_data slice k SHALL be the head entry of FIFO k.
REQ-024 Pop on channel k SHALL occur when out_valid[k] & out_ready[k]; pops on different channels are independent and may coincide.
REQ-025 Latency: a beat accepted in cycle t SHALL appear on out_valid of an empty target channel in cycle t+1; earliest pop t+1.
REQ-026 Simultaneous push and pop on a non-full, non-empty channel SHALL leave occupancy unchanged and preserve order.
REQ-027 Simultaneous push and pop on an empty channel is impossible (out_valid low); push SHALL make occupancy 1.
REQ-028 Beats on each channel SHALL exit in acceptance order; no beat duplicated (except broadcast fan-out) or lost.
REQ-029 out_data of an empty channel is don't-care; out_valid SHALL gate it.
REQ-030 When N is a power of two, out-of-range selects cannot occur and drop_cnt SHALL remain 0.

Reset
REQ-031 rst_n low SHALL asynchronously clear all occupancies, pointers and drop_cnt to 0; out_valid all 0.
REQ-032 During reset in_ready SHALL be 1 for in-range unicast and broadcast (all FIFOs empty) but no beat SHALL be stored.
REQ-033 Reset asserted mid-stream SHALL discard all buffered beats; first beat accepted after rst_n rises is the first delivered.
REQ-034 FIFO storage contents need not be reset.

Verification
REQ-035 N=4: unicast sel=0..3 with data 0x11,0x22,0x33,0x44, all out_ready=1 -> each appears one cycle later only on matching channel, other out_valid 0.
REQ-036 DEPTH=2, out_ready[2]=0, send 0xA1,0xA2,0xA3 to sel=2 -> first two accepted, in_ready=0 for third; raise out_ready[2] -> 0xA1,0xA2 delivered in order, then 0xA3 accepted.
REQ-037 Broadcast 0x5A with channel 1 full -> in_ready=0 until channel 1 pops; then one accept fills all four channels with 0x5A.
REQ-038 N=3, sel=3 with 300 valid beats -> in_ready=1 throughout, no out_valid asserted, drop_cnt reaches and holds 255.
REQ-039 Channel 0 occupancy 1 with continuous push+pop for 10 cycles, data 0..9 -> occupancy stays 1, output sequence in order, no loss.
REQ-040 Fill channels 0 and 3, assert rst_n=0 between clock edges -> out_valid=0 immediately; after release, new beat 0x77 to sel=3 is first seen on channel 3.
